// File: rtl/pgr_uart_cmd_sched_32bit.sv
// Purpose: turn framed UART RX bytes (header, address, optional write data) into one APB command.
// Latency: cmd_en rises the cycle after the final frame byte; busy drops the cycle after cmd_done.
// Backpressure: none on rx; bytes arriving while a command is outstanding are dropped and flagged.
module pgr_uart_cmd_sched_32bit #(
  parameter logic [7:0]  AW         = 8'd24,
  parameter logic [7:0]  DW         = 8'd32,
  parameter logic [7:0]  SW         = 8'd4,
  parameter logic [15:0] RX_TIMEOUT = 16'd50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  output logic [SW-1:0] strb,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          we,
  output logic          cmd_en,
  input  logic          cmd_done,
  output logic          busy,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);

  localparam int AB = int'(AW) / 8;
  localparam int DB = int'(DW) / 8;
  localparam logic [2:0]  A_LAST = 3'(AB - 1);
  localparam logic [2:0]  D_LAST = 3'(DB - 1);
  localparam logic [15:0] TO_LAST = RX_TIMEOUT - 16'd1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     idle_cnt_q, idle_cnt_d;
  logic            cmd_en_q, cmd_en_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            in_frame;
  logic            timeout;

  // Frame parser: next state, field capture, error detection and registered output values.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    strb_d      = strb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = 1'b0;
    in_frame    = (state_q == ADDR) || (state_q == DATA);
    timeout     = in_frame && !rx_vld && (idle_cnt_q == TO_LAST);
    // Inter-byte gap counter only runs while a frame is open; any byte restarts it.
    idle_cnt_d  = (rx_vld || !in_frame) ? 16'd0 : idle_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_data[6:4] == 3'b010) begin
            we_d       = rx_data[7];
            strb_d     = rx_data[SW-1:0];
            wdata_d    = '0;
            byte_cnt_d = '0;
            state_d    = ADDR;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_vld) begin
          for (int i = 0; i < AB; i++)
            if (byte_cnt_q == 3'(i)) addr_d[8*i +: 8] = rx_data;
          if (byte_cnt_q == A_LAST) begin
            byte_cnt_d = '0;
            state_d    = we_q ? DATA : ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DATA: begin
        if (rx_vld) begin
          for (int i = 0; i < DB; i++)
            if (byte_cnt_q == 3'(i)) wdata_d[8*i +: 8] = rx_data;
          if (byte_cnt_q == D_LAST) begin
            byte_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        if (rx_vld) frame_err_d = 1'b1;
      end
      WAIT: begin
        if (cmd_done) state_d = IDLE;
        if (rx_vld) frame_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    cmd_en_d  = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and output registers; reset clears everything, including any pending command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      strb_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      cmd_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      cmd_en_q    <= cmd_en_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign strb      = strb_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign cmd_en    = cmd_en_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/pgr_uart_cmd_sched_32bit.md
# pgr_uart_cmd_sched_32bit

Byte-stream command scheduler that turns framed UART receive bytes into single APB transactions on the 32-bit APB master interface (strb/addr/wdata/we/cmd_en/cmd_done). It parses the header, address and write-data bytes and issues exactly one `cmd_en` per frame. It then holds off the next frame until `cmd_done` returns. It sits between the UART RX byte path and the APB master.

## Interface
Parameters:
- AW, 8'd24, address width; multiple of 8, 8..32
- DW, 8'd32, data width; multiple of 8, 8..32
- SW, 8'd4, strobe width; 1..4
- RX_TIMEOUT, 16'd50000, inter-byte timeout in clk cycles while a frame is open; must be ≥ 2

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, system clock
  - rst_n, input, 1, reset
- rx_data, input, 8, received byte
- rx_vld, input, 1, one-cycle strobe; rx_data is valid when this is high
- strb, output, SW, byte strobe for the transaction
- addr, output, AW, transaction address
- wdata, output, DW, write data
- we, output, 1, 1 = write, 0 = read
- cmd_en, output, 1, one-cycle transaction request
- cmd_done, input, 1, transaction complete (includes APB timeout completion)
- busy, output, 1, high whenever state ≠ IDLE
- frame_err, output, 1, one-cycle pulse on any framing error
- err_cnt, output, 8, saturating error count

## Operation
Frame format, bytes in order:
- Header byte:
  - bit7 = we.
  - bits[6:4] = 3'b010, the sync marker.
  - bits[3:0] = strb; the low SW bits are used.
- Address: AW/8 bytes, LSB first. Byte i is written to addr[8i+7:8i].
- Write data: DW/8 bytes, LSB first. These bytes are present only when we = 1.

State machine: IDLE, ADDR, DATA, ISSUE, WAIT.
- IDLE:
  - On rx_vld with a valid marker: latch we and strb, clear wdata to 0, clear byte_cnt, go to ADDR.
  - On rx_vld with a bad marker: pulse frame_err, stay in IDLE. addr, wdata, strb and we are unchanged.
- ADDR:
  - On rx_vld: store the byte and increment byte_cnt.
  - After the (AW/8)-th byte: go to DATA if we = 1, else ISSUE. byte_cnt clears.
- DATA:
  - On rx_vld: store the byte.
  - After the (DW/8)-th byte: go to ISSUE.
- ISSUE:
  - cmd_en = 1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On cmd_done: go to IDLE.
  - cmd_en is never reasserted in this state.

Timeout and error rules:
- Timeout (ADDR/DATA only):
  - idle_cnt resets on entry to the state and on every rx_vld; otherwise it increments each cycle.
  - When idle_cnt == RX_TIMEOUT-1 and there is no rx_vld in that cycle: pulse frame_err and go to IDLE. No cmd_en is issued.
  - rx_vld in the same cycle as the timeout: the byte wins and is accepted.
- A byte arriving in ISSUE or WAIT is dropped and pulses frame_err. It does not affect addr, wdata or the state.
- err_cnt increments on every frame_err and saturates at 8'hFF.
- Output stability: addr, wdata, strb and we hold their values from before cmd_en until the next header is accepted.

## Timing
- Reset value of every output is 0: strb, addr, wdata, we, cmd_en, busy, frame_err, err_cnt. State resets to IDLE.
- All outputs are registered.
- Latency: final byte accepted at edge N → cmd_en high in cycle N+1 (one cycle). strb, addr, wdata and we are already stable in that cycle.
- cmd_done sampled high at edge M in WAIT → busy low from cycle M+1. A header byte arriving at M+1 is accepted.
- busy goes high the cycle after the header is accepted.
- frame_err is high for the single cycle after the offending event.
- Reset mid-frame or mid-WAIT: all outputs return to 0 immediately, and a pending cmd_done is ignored.

## Test plan
- Write frame: send 0xAF,0x10,0x20,0x30,0x44,0x33,0x22,0x11.
  - Expect addr=0x302010, wdata=0x11223344, we=1, strb=0xF.
  - Expect cmd_en high for exactly one cycle, one cycle after the last byte.
  - cmd_done 5 cycles later → busy low on the next cycle.
- Read frame: send 0x23,0x04,0x00,0x00.
  - Expect we=0, strb=0x3, addr=0x000004, wdata=0.
  - Expect one cmd_en pulse. No DATA state is entered.
- Bad header: send 0x80 → frame_err pulse, err_cnt=1, busy stays 0. A following valid write frame completes normally.
- Timeout: set RX_TIMEOUT=100, send 0xAF,0x10, then no bytes for 100 cycles.
  - Expect frame_err, err_cnt+1, busy=0, no cmd_en.
  - Repeat with a byte arriving exactly in the timeout cycle → the frame continues.
- Bytes during WAIT: hold cmd_done low and inject 3 bytes.
  - Expect 3 frame_err pulses and addr/wdata unchanged.
  - Then inject 300 bad headers → err_cnt saturates at 0xFF.
- Reset mid-frame: assert rst_n low after 2 address bytes → all outputs 0 at once. After release, a clean read frame works.
